// File: rtl/pauli_frame_pkg.sv
// Shared types and constants for the Pauli frame updater.
// Exports:
//   pauli_t      2-bit {Z,X} Pauli value
//   PAULI_*      the four single-qubit Paulis
//   corr_t       buffered correction {addr, pauli}
//   pfu_state_e  updater FSM states
package pauli_frame_pkg;

  localparam int unsigned PFU_NUM_QUBITS = 49;
  localparam int unsigned PFU_ADDR_W     = $clog2(PFU_NUM_QUBITS);

  typedef logic [1:0] pauli_t;

  localparam pauli_t PAULI_I = 2'b00;
  localparam pauli_t PAULI_X = 2'b01;
  localparam pauli_t PAULI_Z = 2'b10;
  localparam pauli_t PAULI_Y = 2'b11;

  // The address field is sized by PFU_ADDR_W; the updater's ADDR_W must match it.
  typedef struct packed {
    logic [PFU_ADDR_W-1:0] addr;
    pauli_t                pauli;
  } corr_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StDump
  } pfu_state_e;

endpackage

// File: rtl/pauli_frame_updater_if.sv
// Correction ingress stream (valid/ready) between the decoder and the updater.
// Signals:
//   corr_valid  correction offered (master -> slave)
//   corr_ready  correction accepted when high with corr_valid (slave -> master)
//   corr_addr   target qubit
//   corr_pauli  {Z,X} correction
interface pauli_frame_updater_if
  import pauli_frame_pkg::*;
#(
  parameter int unsigned ADDR_W = PFU_ADDR_W
) ();

  logic              corr_valid;
  logic              corr_ready;
  logic [ADDR_W-1:0] corr_addr;
  pauli_t            corr_pauli;

  modport master (
    output corr_valid,
    output corr_addr,
    output corr_pauli,
    input  corr_ready
  );

  modport slave (
    input  corr_valid,
    input  corr_addr,
    input  corr_pauli,
    output corr_ready
  );

endinterface

// File: rtl/corr_fifo.sv
// Synchronous FIFO of corr_t entries. Pointers carry one extra MSB so that
// full and empty are distinguished without a separate occupancy counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes pointers)
//   push_i, wdata_i   enqueue request and data (ignored while full)
//   pop_i             dequeue request (ignored while empty)
//   rdata_o           current head entry
//   full_o, empty_o   status flags
module corr_fifo
  import pauli_frame_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  corr_t wdata_i,
  input  logic  pop_i,
  output corr_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  corr_t         mem_q [Depth];
  corr_t         mem_d [Depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push_i && !full_o) begin
      mem_d[wptr_q[PtrW-1:0]] = wdata_i;
      wptr_d                  = wptr_q + PtrOne;
    end
    if (pop_i && !empty_o) begin
      rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pauli_frame_updater.sv
// Read-modify-write front end for the LUTRAM Pauli frame tracker.
// Buffers decoder corrections and XORs one per cycle into the tracker frame;
// on dump_req it drains the buffer, then sweeps every frame entry out on the
// readout stream, optionally zeroing each entry as it is read.
// Optional feature macro: PFU_STATS_EN adds applied_cnt / dropped_cnt.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   corr (slave modport)           correction stream {valid, ready, addr, pauli}
//   dump_req, dump_clear           start drain+readout; zero entries as dumped
//   dump_busy, dump_done           sweep in progress; pulse after the last beat
//   dump_valid/addr/pauli          registered readout beat
//   err_oob                        sticky out-of-range address seen
//   trk_wr_en/addr/pauli           tracker synchronous write port
//   trk_rd_addr, trk_rd_pauli      tracker asynchronous read port
//   applied_cnt, dropped_cnt       saturating statistics (PFU_STATS_EN only)
module pauli_frame_updater
  import pauli_frame_pkg::*;
#(
  parameter int unsigned NUM_QUBITS = PFU_NUM_QUBITS,
  parameter int unsigned ADDR_W     = $clog2(NUM_QUBITS),
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  pauli_frame_updater_if.slave corr,
  input  logic                dump_req,
  input  logic                dump_clear,
  output logic                dump_busy,
  output logic                dump_valid,
  output logic [ADDR_W-1:0]   dump_addr,
  output pauli_t              dump_pauli,
  output logic                dump_done,
  output logic                err_oob,
  output logic                trk_wr_en,
  output logic [ADDR_W-1:0]   trk_wr_addr,
  output pauli_t              trk_wr_pauli,
  output logic [ADDR_W-1:0]   trk_rd_addr,
  input  pauli_t              trk_rd_pauli
`ifdef PFU_STATS_EN
  ,
  output logic [CNT_W-1:0]    applied_cnt,
  output logic [CNT_W-1:0]    dropped_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_QUBITS - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  pfu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              clear_q, clear_d;
  logic              busy_q, busy_d;
  logic              dvalid_q, dvalid_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  pauli_t            dpauli_q, dpauli_d;
  logic              done_q, done_d;
  logic              oob_q, oob_d;

  logic  fifo_full, fifo_empty;
  corr_t fifo_head;
  logic  accept, in_range, push, drop, pop;

  // Ready depends only on registered state, never on this cycle's pop.
  assign corr.corr_ready = (state_q == StIdle) && !fifo_full;

  assign accept   = corr.corr_valid && corr.corr_ready;
  assign in_range = 32'(corr.corr_addr) < NUM_QUBITS;
  assign push     = accept && in_range && (corr.corr_pauli != PAULI_I);
  assign drop     = accept && !push;
  assign pop      = ((state_q == StIdle) || (state_q == StDrain)) && !fifo_empty;

  corr_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_corr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ('{addr: corr.corr_addr, pauli: corr.corr_pauli}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    clear_d      = clear_q;
    busy_d       = busy_q;
    dvalid_d     = 1'b0;
    daddr_d      = '0;
    dpauli_d     = PAULI_I;
    done_d       = dvalid_q && (daddr_q == LastAddr);
    oob_d        = oob_q || (accept && !in_range);
    trk_wr_en    = 1'b0;
    trk_wr_addr  = '0;
    trk_wr_pauli = PAULI_I;
    trk_rd_addr  = '0;

    // Busy drops together with the done pulse; a new request re-raises it.
    if (done_d) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d = StDrain;
          clear_d = dump_clear;
          busy_d  = 1'b1;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDump;
          k_d     = '0;
        end
      end
      StDump: begin
        trk_rd_addr = k_q;
        dvalid_d    = 1'b1;
        daddr_d     = k_q;
        dpauli_d    = trk_rd_pauli;
        if (clear_q) begin
          trk_wr_en    = 1'b1;
          trk_wr_addr  = k_q;
          trk_wr_pauli = PAULI_I;
        end
        if (k_q == LastAddr) begin
          state_d = StIdle;
          k_d     = '0;
        end else begin
          k_d = k_q + AddrOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Apply never overlaps the sweep: pop is only possible in Idle/Drain.
    if (pop) begin
      trk_rd_addr  = fifo_head.addr;
      trk_wr_en    = 1'b1;
      trk_wr_addr  = fifo_head.addr;
      trk_wr_pauli = trk_rd_pauli ^ fifo_head.pauli;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      dvalid_q <= 1'b0;
      daddr_q  <= '0;
      dpauli_q <= PAULI_I;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      dvalid_q <= dvalid_d;
      daddr_q  <= daddr_d;
      dpauli_q <= dpauli_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
    end
  end

  assign dump_busy  = busy_q;
  assign dump_valid = dvalid_q;
  assign dump_addr  = daddr_q;
  assign dump_pauli = dpauli_q;
  assign dump_done  = done_q;
  assign err_oob    = oob_q;

`ifdef PFU_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] applied_q, applied_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;

  always_comb begin
    applied_d = applied_q;
    dropped_d = dropped_q;
    if (pop && (applied_q != '1)) begin
      applied_d = applied_q + CntOne;
    end
    if (drop && (dropped_q != '1)) begin
      dropped_d = dropped_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      applied_q <= '0;
      dropped_q <= '0;
    end else begin
      applied_q <= applied_d;
      dropped_q <= dropped_d;
    end
  end

  assign applied_cnt = applied_q;
  assign dropped_cnt = dropped_q;
`else
  // Counters are compiled out; keep the width parameter and drop strobe referenced.
  logic [CNT_W-1:0] unused_cnt_w;
  logic             unused_drop;
  assign unused_cnt_w = '0;
  assign unused_drop  = drop;
`endif

endmodule

// File: tb/tb_pauli_frame_updater.sv
// Directed self-checking bench for pauli_frame_updater with a behavioural
// LUTRAM tracker (asynchronous read, synchronous write).
module tb_pauli_frame_updater;
  import pauli_frame_pkg::*;

  localparam int unsigned NQ = 49;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dump_req = 1'b0;
  logic          dump_clear = 1'b0;
  logic          dump_busy, dump_valid, dump_done, err_oob;
  logic [AW-1:0] dump_addr;
  pauli_t        dump_pauli;
  logic          trk_wr_en;
  logic [AW-1:0] trk_wr_addr, trk_rd_addr;
  pauli_t        trk_wr_pauli, trk_rd_pauli;
`ifdef PFU_STATS_EN
  logic [15:0]   applied_cnt, dropped_cnt;
`endif

  pauli_t trk_mem [NQ] = '{default: 2'b00};

  int errors = 0;
  int checks = 0;

  // Dump capture results
  pauli_t got [NQ];
  int     nbeats, last_addr, last_cyc, done_cyc, addr_err;
  logic   done_seen, busy_at_done;

  pauli_frame_updater_if #(.ADDR_W(AW)) corr_if ();

  pauli_frame_updater dut (
    .clk          (clk),
    .rst          (rst),
    .corr         (corr_if.slave),
    .dump_req     (dump_req),
    .dump_clear   (dump_clear),
    .dump_busy    (dump_busy),
    .dump_valid   (dump_valid),
    .dump_addr    (dump_addr),
    .dump_pauli   (dump_pauli),
    .dump_done    (dump_done),
    .err_oob      (err_oob),
    .trk_wr_en    (trk_wr_en),
    .trk_wr_addr  (trk_wr_addr),
    .trk_wr_pauli (trk_wr_pauli),
    .trk_rd_addr  (trk_rd_addr),
    .trk_rd_pauli (trk_rd_pauli)
`ifdef PFU_STATS_EN
    ,
    .applied_cnt  (applied_cnt),
    .dropped_cnt  (dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign trk_rd_pauli = (32'(trk_rd_addr) < NQ) ? trk_mem[trk_rd_addr] : 2'b00;

  always @(posedge clk) begin
    if (trk_wr_en && (32'(trk_wr_addr) < NQ)) trk_mem[trk_wr_addr] <= trk_wr_pauli;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int addr, input pauli_t p);
    corr_if.corr_valid = 1'b1;
    corr_if.corr_addr  = AW'(addr);
    corr_if.corr_pauli = p;
  endtask

  // Collect one full sweep; entered at a sample point (edge + 2).
  task automatic run_dump();
    int cyc;
    for (int i = 0; i < NQ; i++) got[i] = 2'b00;
    nbeats = 0; last_addr = -1; last_cyc = -1; done_cyc = -1; addr_err = 0;
    done_seen = 1'b0; busy_at_done = 1'b1;
    cyc = 0;
    while (!done_seen && cyc < 200) begin
      if (dump_valid) begin
        if (32'(dump_addr) != nbeats) addr_err++;
        if (32'(dump_addr) < NQ) got[dump_addr] = dump_pauli;
        nbeats++;
        last_addr = 32'(dump_addr);
        last_cyc  = cyc;
      end
      if (dump_done) begin
        done_seen    = 1'b1;
        done_cyc     = cyc;
        busy_at_done = dump_busy;
      end else begin
        tick();
        #1;
        cyc++;
      end
    end
  endtask

  initial begin
    int nonzero;
    int found;
    corr_if.corr_valid = 1'b0;
    corr_if.corr_addr  = '0;
    corr_if.corr_pauli = PAULI_I;

    // Reset state
    tick(); tick(); #1;
    check("rst_dump_valid", 32'(dump_valid), 0);
    check("rst_dump_busy", 32'(dump_busy), 0);
    check("rst_dump_done", 32'(dump_done), 0);
    check("rst_err_oob", 32'(err_oob), 0);
    check("rst_trk_wr_en", 32'(trk_wr_en), 0);
    check("rst_trk_rd_addr", 32'(trk_rd_addr), 0);
    rst = 1'b0;
    tick(); #1;
    check("post_rst_ready", 32'(corr_if.corr_ready), 1);
    check("idle_wr_en", 32'(trk_wr_en), 0);

    // Single apply: X then Z to qubit 5, back-to-back
    offer(5, PAULI_X); #1;
    check("t1_ready", 32'(corr_if.corr_ready), 1);
    tick();
    offer(5, PAULI_Z); #1;
    check("t1_wr_en_n1", 32'(trk_wr_en), 1);
    check("t1_wr_addr_n1", 32'(trk_wr_addr), 5);
    check("t1_wr_pauli_n1", 32'(trk_wr_pauli), 32'(PAULI_X));
    tick();
    corr_if.corr_valid = 1'b0; #1;
    check("t1_wr_pauli_n2", 32'(trk_wr_pauli), 32'(PAULI_Y));
    tick(); #1;
    check("t1_entry5", 32'(trk_mem[5]), 32'(PAULI_Y));
    check("t1_idle_wr_en", 32'(trk_wr_en), 0);
`ifdef PFU_STATS_EN
    check("t1_applied_cnt", 32'(applied_cnt), 2);
`endif

    // Filtering: identity at qubit 3, X at out-of-range qubit 49
    offer(3, PAULI_I);
    tick();
    offer(49, PAULI_X);
    tick();
    corr_if.corr_valid = 1'b0; #1;
    check("flt_err_oob", 32'(err_oob), 1);
    check("flt_no_apply", 32'(trk_wr_en), 0);
    tick(); #1;
    check("flt_entry3", 32'(trk_mem[3]), 0);
    check("flt_entry5_kept", 32'(trk_mem[5]), 32'(PAULI_Y));
`ifdef PFU_STATS_EN
    check("flt_dropped_cnt", 32'(dropped_cnt), 2);
    check("flt_applied_cnt", 32'(applied_cnt), 2);
`endif

    // Burst of FIFO_DEPTH corrections: ready stays high since one pops per cycle
    for (int i = 0; i < 8; i++) begin
      offer(10 + i, PAULI_X); #1;
      check($sformatf("burst_ready_%0d", i), 32'(corr_if.corr_ready), 1);
      tick();
    end
    corr_if.corr_valid = 1'b0;
    tick(); tick(); #1;
    check("burst_entry10", 32'(trk_mem[10]), 32'(PAULI_X));
    check("burst_entry17", 32'(trk_mem[17]), 32'(PAULI_X));

    // Dump with clear: entry 0 = X, entry 48 = Z
    offer(0, PAULI_X);
    tick();
    offer(48, PAULI_Z);
    tick();
    corr_if.corr_valid = 1'b0;
    tick(); tick();
    dump_req = 1'b1; dump_clear = 1'b1;
    tick();
    dump_req = 1'b0; dump_clear = 1'b0; #1;
    check("dc_busy", 32'(dump_busy), 1);
    check("dc_ready_low", 32'(corr_if.corr_ready), 0);
    run_dump();
    check("dc_done_seen", 32'(done_seen), 1);
    check("dc_nbeats", 32'(nbeats), 49);
    check("dc_addr_order", 32'(addr_err), 0);
    check("dc_last_addr", 32'(last_addr), 48);
    check("dc_done_latency", 32'(done_cyc), 32'(last_cyc + 1));
    check("dc_busy_at_done", 32'(busy_at_done), 0);
    check("dc_beat0", 32'(got[0]), 32'(PAULI_X));
    check("dc_beat3", 32'(got[3]), 32'(PAULI_I));
    check("dc_beat5", 32'(got[5]), 32'(PAULI_Y));
    check("dc_beat10", 32'(got[10]), 32'(PAULI_X));
    check("dc_beat48", 32'(got[48]), 32'(PAULI_Z));
    tick(); #1;
    check("dc_done_pulse", 32'(dump_done), 0);
    nonzero = 0;
    for (int i = 0; i < NQ; i++) if (trk_mem[i] != 2'b00) nonzero++;
    check("dc_frame_cleared", 32'(nonzero), 0);

    // Dump after drain: dump_req arrives with the last accepted correction
    offer(1, PAULI_X);  tick();
    offer(2, PAULI_Z);  tick();
    offer(30, PAULI_X); tick();
    offer(1, PAULI_Z); dump_req = 1'b1; dump_clear = 1'b0; #1;
    check("dd_last_ready", 32'(corr_if.corr_ready), 1);
    tick();
    corr_if.corr_valid = 1'b0; dump_req = 1'b0; #1;
    check("dd_ready_low", 32'(corr_if.corr_ready), 0);
    check("dd_busy", 32'(dump_busy), 1);
    run_dump();
    check("dd_done_seen", 32'(done_seen), 1);
    check("dd_nbeats", 32'(nbeats), 49);
    check("dd_beat0", 32'(got[0]), 32'(PAULI_I));
    check("dd_beat1", 32'(got[1]), 32'(PAULI_Y));
    check("dd_beat2", 32'(got[2]), 32'(PAULI_Z));
    check("dd_beat30", 32'(got[30]), 32'(PAULI_X));
    tick(); #1;
    check("dd_entry1_kept", 32'(trk_mem[1]), 32'(PAULI_Y));

    // Reset at beat 20 of a clearing dump
    dump_req = 1'b1; dump_clear = 1'b1;
    tick();
    dump_req = 1'b0; dump_clear = 1'b0; #1;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (dump_valid && (dump_addr == AW'(20))) found = 1;
      else begin
        tick(); #1;
      end
    end
    check("rm_reached_beat20", 32'(found), 1);
    rst = 1'b1;
    tick(); #1;
    check("rm_dump_valid", 32'(dump_valid), 0);
    check("rm_dump_busy", 32'(dump_busy), 0);
    check("rm_trk_wr_en", 32'(trk_wr_en), 0);
    rst = 1'b0;
    tick(); #1;
    check("rm_ready", 32'(corr_if.corr_ready), 1);
    check("rm_err_oob_cleared", 32'(err_oob), 0);
    check("rm_entry1_cleared", 32'(trk_mem[1]), 0);
    check("rm_entry30_kept", 32'(trk_mem[30]), 32'(PAULI_X));
    tick(); tick(); #1;
    check("rm_no_dump", 32'(dump_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pauli_frame_updater.md
# pauli_frame_updater

Read-modify-write front end for the LUTRAM Pauli frame tracker. It accepts decoder corrections on a valid/ready stream and buffers them in a small FIFO. Each correction is XOR-applied into the tracker's stored frame, one per cycle, through the tracker's asynchronous read and synchronous write ports. On request it drains pending corrections, then sweeps the whole frame out on a readout stream, optionally clearing each entry for the next QEC round.

## Interface
- `NUM_QUBITS`, 49: frame entries; must match the tracker.
- `ADDR_W`, `$clog2(NUM_QUBITS)`: qubit address width.
- `FIFO_DEPTH`, 8: correction FIFO depth; power of two, ≥2.
- `CNT_W`, 16: statistics counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `corr_valid` in 1: correction offered.
- `corr_ready` out 1: correction accepted when high with `corr_valid`.
- `corr_addr` in `ADDR_W`: target qubit.
- `corr_pauli` in 2: {Z,X} correction.
- `dump_req` in 1: single-cycle pulse; start drain and readout.
- `dump_clear` in 1: sampled with `dump_req`; zero each entry as it is dumped.
- `dump_busy` out 1: high from `dump_req` acceptance through `dump_done`.
- `dump_valid` out 1: readout beat.
- `dump_addr` out `ADDR_W`: beat address.
- `dump_pauli` out 2: frame value before any clear.
- `dump_done` out 1: one-cycle pulse after the last beat.
- `err_oob` out 1: sticky; an out-of-range address was offered.
- `trk_wr_en` out 1, `trk_wr_addr` out `ADDR_W`, `trk_wr_pauli` out 2: tracker write port.
- `trk_rd_addr` out `ADDR_W`, `trk_rd_pauli` in 2: tracker asynchronous read port.
- `applied_cnt` out `CNT_W`, `dropped_cnt` out `CNT_W`: present only with `PFU_STATS_EN`.

## Operation
- **States:** `IDLE` (normal update), `DRAIN`, `DUMP`.
  - `IDLE` → `DRAIN` on `dump_req`.
  - `DRAIN` → `DUMP` when the FIFO is empty.
  - `DUMP` → `IDLE` after address `NUM_QUBITS-1` is read.
  - `dump_req` outside `IDLE` is ignored.
- **Ingress handshake:**
  - `corr_ready = (state==IDLE) && !full`, computed from registered state only.
  - No enqueue while full, even when a pop occurs in the same cycle.
- **Ingress filtering:** applies only to accepted beats.
  - `corr_pauli==2'b00` is dropped, not enqueued, and increments `dropped_cnt`.
  - `corr_addr ≥ NUM_QUBITS` is dropped, increments `dropped_cnt`, and sets `err_oob`.
  - `err_oob` is cleared only by `rst`.
- **Apply:** in `IDLE` or `DRAIN` with the FIFO non-empty, every cycle:
  - `trk_rd_addr = head.addr`.
  - `trk_wr_en = 1`, `trk_wr_addr = head.addr`, `trk_wr_pauli = trk_rd_pauli ^ head.pauli`.
  - Pop the head; increment `applied_cnt`.
- **Dump sweep:** a counter `k` runs 0..`NUM_QUBITS-1`, one address per cycle.
  - `trk_rd_addr = k`.
  - If `dump_clear` was latched: `trk_wr_en = 1`, `trk_wr_addr = k`, `trk_wr_pauli = 00`.
- **Idle tracker port:** when nothing is being applied or dumped, `trk_wr_en = 0` and `trk_rd_addr = 0`.
- **Counters:** saturate at all-ones.

## Timing
- **Reset values:** every output is 0 except `corr_ready`, which is 1 in the cycle after `rst` deasserts. After reset the FIFO is empty, state is `IDLE`, and counters are 0.
- **Apply latency:** a correction accepted in cycle N is applied (tracker write) in cycle N+1 at the earliest and is visible on tracker reads in N+2.
- **Back-to-back corrections:** consecutive corrections to the same address are exact, because each apply reads the value written in the preceding cycle. No bypass is needed.
- **Throughput:** 1 correction/cycle sustained.
- **Readout registering:** `dump_valid`, `dump_addr` and `dump_pauli` are registered, so address k read in cycle T appears in T+1.
- **Dump completion:** `dump_done` pulses in the cycle after the last beat; `dump_busy` falls in that same cycle.
- **Readout flow control:** the readout stream has no backpressure; the consumer must accept every beat.
- **Reset mid-dump or mid-drain:** return to `IDLE` with the FIFO flushed and the dump outputs low. Tracker contents are not restored, so a partially cleared frame stays partial.

## Configuration
- Macro: `PFU_STATS_EN`.
- **Defined:** `applied_cnt` and `dropped_cnt` ports and their counters exist.
- **Undefined:** the ports and logic are absent. All other behaviour, including `err_oob`, is unchanged.

## Structure
- **Shared package `pauli_frame_pkg`:**
  - `pauli_t` (2-bit {Z,X}).
  - Constants `PAULI_I`, `PAULI_X`, `PAULI_Z`, `PAULI_Y`.
  - `corr_t` struct {addr, pauli}.
  - `pfu_state_e` enum.
- **Sub-module `corr_fifo`:** synchronous FIFO of `corr_t` with `full`/`empty`, depth `FIFO_DEPTH`, and wrap-around pointers using an extra MSB.

## Test plan
- **Single apply:** tracker all-zero; offer (addr 5, X=01) then (addr 5, Z=10) back-to-back → tracker entry 5 = 11 (Y) by cycle N+3; `applied_cnt=2`.
- **Backpressure:** hold `corr_valid` with `trk_rd_pauli`-producing writes stalled by `dump_req` in DRAIN; in IDLE, enqueue 8 in one burst with `FIFO_DEPTH=8` → `corr_ready` never drops (pop each cycle); force full via DRAIN → `corr_ready=0`.
- **Filtering:** offer pauli 00 at addr 3 and addr 49 with pauli 01 → both dropped; `dropped_cnt=2`, `err_oob=1`, tracker unchanged.
- **Dump with clear:** set entries 0=01, 48=10; `dump_req` with `dump_clear=1` → 49 beats, beat 0 = 01, beat 48 = 10, `dump_done` one cycle after beat 48; tracker all-zero afterwards.
- **Dump after drain:** enqueue 4 corrections, then `dump_req` in the same cycle as the last accept → dump starts only after the FIFO is empty, and the beats reflect all 4 corrections.
- **Reset mid-dump:** assert `rst` at beat 20 → `dump_valid=0` and `dump_busy=0` next cycle; `corr_ready=1` after deassert.
